wb_spram_port: RTL and testbench

// Wishbone B4 pipelined responder that drives one byte-write single-port RAM (spram_byte_write_ram_wr_first).
// - Converts bus strobes into RAM address, data and column-enable cycles.
// - Tracks the RAM's fixed read latency and returns in-order acks or errors.
// - Optional zero-fill sweep after reset.
// - Sits between the interconnect and any on-chip RAM bank.

---
 rtl/wb_spram_pkg.sv | 16 +
 rtl/wb_spram_port_if.sv | 29 ++
 rtl/wb_resp_pipe.sv | 41 ++++
 rtl/wb_spram_port.sv | 99 +++++++++
 tb/tb_wb_spram_port.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_spram_pkg.sv
// Shared types and helpers for the Wishbone single-port RAM responder.
package wb_spram_pkg;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

  // RAM_PERFORMANCE is carried as a packed 16-character string.
  localparam int unsigned PerfStrW = 128;

  function automatic int unsigned lat(input logic [PerfStrW-1:0] perf);
    return (perf == PerfStrW'("LOW_LATENCY")) ? 32'd1 : 32'd2;
  endfunction

endpackage

// File: rtl/wb_spram_port_if.sv
// Wishbone B4 pipelined bus bundle between an interconnect master and the RAM responder.
interface wb_spram_port_if #(
  parameter int unsigned AW     = 10,
  parameter int unsigned DW     = 32,
  parameter int unsigned NB_COL = 4
);

  logic [AW:0]       wb_adr;
  logic [DW-1:0]     wb_dat_w;
  logic [DW-1:0]     wb_dat_r;
  logic [NB_COL-1:0] wb_sel;
  logic              wb_we;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_stall;
  logic              wb_ack;
  logic              wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_dat_r, wb_stall, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_dat_r, wb_stall, wb_ack, wb_err
  );

endinterface

// File: rtl/wb_resp_pipe.sv
// Fixed-depth {valid, err} response shift register; squash clears every stage at once.
module wb_resp_pipe #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic err_i,
  input  logic squash_i,
  output logic valid_o,
  output logic err_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] err_q, err_d;

  always_comb begin
    valid_d    = '0;
    err_d      = '0;
    valid_d[0] = push_i & ~squash_i;
    err_d[0]   = err_i;
    for (int i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1] & ~squash_i;
      err_d[i]   = err_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign err_o   = valid_q[Depth-1] & err_q[Depth-1];

endmodule

// File: rtl/wb_spram_port.sv
// Wishbone B4 pipelined responder for a byte-write, write-first single-port RAM with an
// optional zero-fill sweep after reset.
module wb_spram_port
  import wb_spram_pkg::*;
#(
  parameter int unsigned          NB_COL          = 4,
  parameter int unsigned          COL_WIDTH       = 8,
  parameter int unsigned          RAM_DEPTH       = 1024,
  parameter logic [PerfStrW-1:0]  RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter bit                   CLEAR_ON_RESET  = 1'b1,
  localparam int unsigned         AW              = $clog2(RAM_DEPTH),
  localparam int unsigned         DW              = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_spram_port_if.slave    wb,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_din,
  output logic [NB_COL-1:0] ram_we,
  input  logic [DW-1:0]     ram_dout,
  output logic              init_done
);

  localparam int unsigned L = lat(RAM_PERFORMANCE);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic run;
  logic accept;
  logic in_range;
  logic resp_valid;
  logic resp_err;

  // While reset is held the port looks stalled regardless of the stored state.
  assign run      = rst_n & (state_q == StRun);
  assign in_range = wb.wb_adr < (AW + 1)'(RAM_DEPTH);
  assign accept   = run & wb.wb_cyc & wb.wb_stb;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ram_addr = wb.wb_adr[AW-1:0];
    ram_din  = wb.wb_dat_w;
    ram_we   = '0;
    unique case (state_q)
      StClear: begin
        ram_addr = cnt_q;
        ram_din  = '0;
        ram_we   = '1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == AW'(RAM_DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept && wb.wb_we && in_range) begin
          ram_we = wb.wb_sel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? StClear : StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dropping cyc abandons every outstanding response, including the one due this cycle.
  wb_resp_pipe #(
    .Depth (L)
  ) u_resp_pipe (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .push_i   (accept),
    .err_i    (~in_range),
    .squash_i (~wb.wb_cyc),
    .valid_o  (resp_valid),
    .err_o    (resp_err)
  );

  assign wb.wb_ack   = resp_valid & ~resp_err & wb.wb_cyc;
  assign wb.wb_err   = resp_valid & resp_err & wb.wb_cyc;
  assign wb.wb_stall = ~run;
  assign wb.wb_dat_r = ram_dout;
  assign init_done   = run;

  a_ack_err_excl: assert property (@(posedge clk) !(wb.wb_ack && wb.wb_err));

  a_no_oor_write: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StRun && !in_range) |-> (ram_we == '0));

endmodule

// File: tb/tb_wb_spram_port.sv
// Randomized bench for wb_spram_port: a write-first RAM model sits on the RAM side and a
// word-array/response-queue reference model predicts every ack, err and read word.
module tb_wb_spram_port;

  localparam int unsigned NbCol = 4;
  localparam int unsigned ColW  = 8;
  localparam int unsigned Depth = 24;
  localparam int unsigned Aw    = 5;
  localparam int unsigned Dw    = 32;
  localparam int          Lat   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_spram_port_if #(.AW(Aw), .DW(Dw), .NB_COL(NbCol)) bus ();

  logic [Aw-1:0]    ram_addr;
  logic [Dw-1:0]    ram_din;
  logic [Dw-1:0]    ram_dout;
  logic [NbCol-1:0] ram_we;
  logic             init_done;

  wb_spram_port #(
    .NB_COL          (NbCol),
    .COL_WIDTH       (ColW),
    .RAM_DEPTH       (Depth),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
    .CLEAR_ON_RESET  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  function automatic logic [Dw-1:0] merge(input logic [Dw-1:0] old, input logic [Dw-1:0] nw,
                                          input logic [NbCol-1:0] sel);
    logic [Dw-1:0] r;
    r = old;
    for (int b = 0; b < NbCol; b++) begin
      if (sel[b]) r[b*ColW +: ColW] = nw[b*ColW +: ColW];
    end
    return r;
  endfunction

  // Attached RAM: write-first, two-cycle read latency.
  logic [Dw-1:0] ram_mem [2**Aw];
  logic [Dw-1:0] ram_p1, ram_p2;
  always_ff @(posedge clk) begin
    ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_din, ram_we);
    ram_p1            <= merge(ram_mem[ram_addr], ram_din, ram_we);
    ram_p2            <= ram_p1;
  end
  assign ram_dout = ram_p2;

  // Reference model.
  typedef struct {
    int            due;
    bit            err;
    bit            is_rd;
    logic [Dw-1:0] dat;
  } resp_t;

  logic [Dw-1:0] ref_mem [Depth];
  resp_t         exp_q[$];
  int            cyc_n    = 0;
  int            n_checks = 0;
  int            n_errs   = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [Dw-1:0] got, input logic [Dw-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic check_resp();
    resp_t r;
    bit    e_ack = 1'b0;
    bit    e_err = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
      r     = exp_q.pop_front();
      e_ack = !r.err;
      e_err = r.err;
      if (r.is_rd && !r.err) check("rdata", bus.wb_dat_r, r.dat);
    end
    check("ack", 32'(bus.wb_ack), 32'(e_ack));
    check("err", 32'(bus.wb_err), 32'(e_err));
  endtask

  task automatic bus_cycle(input bit cyc, input bit stb, input bit we, input int adr,
                           input logic [Dw-1:0] dat, input logic [NbCol-1:0] sel);
    resp_t            r;
    bit               in_r;
    logic [NbCol-1:0] exp_we;
    @(negedge clk);
    check_resp();
    bus.wb_cyc   = cyc;
    bus.wb_stb   = stb;
    bus.wb_we    = we;
    bus.wb_adr   = (Aw + 1)'(adr);
    bus.wb_dat_w = dat;
    bus.wb_sel   = sel;
    if (!cyc) exp_q.delete();
    #1;
    in_r   = adr < int'(Depth);
    exp_we = (cyc && stb && we && in_r) ? sel : '0;
    check("stall", 32'(bus.wb_stall), 32'(0));
    check("ram_we", 32'(ram_we), 32'(exp_we));
    if (cyc && stb) begin
      if (we && in_r) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
      r.due   = cyc_n + Lat;
      r.err   = !in_r;
      r.is_rd = !we;
      r.dat   = (in_r && !we) ? ref_mem[adr] : '0;
      exp_q.push_back(r);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b1, 1'b0, 1'b0, 0, '0, '0);
  endtask

  // Caller is just past a negedge; rst_n falls immediately so the next edge resets.
  task automatic do_reset(input int stop_at);
    rst_n      = 1'b0;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
    bus.wb_adr = '0;
    bus.wb_sel = '0;
    exp_q.delete();
    #1;
    check("rst_stall", 32'(bus.wb_stall), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < int'(Depth); k++) begin
      #1;
      check("sweep_stall", 32'(bus.wb_stall), 32'(1));
      check("sweep_addr", 32'(ram_addr), 32'(k));
      check("sweep_we", 32'(ram_we), 32'(4'hF));
      check("sweep_din", ram_din, '0);
      check("sweep_done", 32'(init_done), 32'(0));
      check("sweep_ack", 32'({bus.wb_ack, bus.wb_err}), 32'(0));
      if (k == stop_at) return;
      @(negedge clk);
    end
    #1;
    check("init_done", 32'(init_done), 32'(1));
    for (int i = 0; i < int'(Depth); i++) ref_mem[i] = '0;
  endtask

  initial begin
    do_reset(-1);

    // Freshly cleared RAM reads as zero, including the top word.
    bus_cycle(1'b1, 1'b1, 1'b0, 0, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b0, int'(Depth) - 1, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b0, 11, '0, '0);
    idle(Lat + 1);

    // Partial-lane overwrite then immediate read-back.
    bus_cycle(1'b1, 1'b1, 1'b1, 5, 32'hDEADBEEF, 4'hF);
    bus_cycle(1'b1, 1'b1, 1'b1, 5, 32'h000000AA, 4'h1);
    bus_cycle(1'b1, 1'b1, 1'b0, 5, '0, '0);
    idle(Lat + 1);

    // Eight back-to-back reads after filling distinct words.
    for (int i = 0; i < 8; i++) bus_cycle(1'b1, 1'b1, 1'b1, i + 8, 32'h1000_0000 + i * 32'h111, 4'hF);
    for (int i = 0; i < 8; i++) bus_cycle(1'b1, 1'b1, 1'b0, i + 8, '0, '0);
    idle(Lat + 1);

    // Out-of-range accesses, including one that aliases word 5 in the low address bits.
    bus_cycle(1'b1, 1'b1, 1'b0, int'(Depth), '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b0, 63, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b1, 37, 32'h12345678, 4'hF);
    bus_cycle(1'b1, 1'b1, 1'b1, int'(Depth), 32'hCAFEF00D, 4'hF);
    bus_cycle(1'b1, 1'b1, 1'b0, 5, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b1, 6, 32'h55555555, 4'h0);
    bus_cycle(1'b1, 1'b1, 1'b0, 6, '0, '0);
    idle(Lat + 1);

    // Abandon in-flight reads by dropping cyc, then resume.
    bus_cycle(1'b1, 1'b1, 1'b0, 8, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b0, 9, '0, '0);
    bus_cycle(1'b0, 1'b0, 1'b0, 0, '0, '0);
    for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b0, 1'b0, 0, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b0, 10, '0, '0);
    idle(Lat + 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit cyc, stb, we;
      int adr;
      cyc = ($urandom_range(0, 19) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      adr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(Depth, 63))
                                        : int'($urandom_range(0, Depth - 1));
      bus_cycle(cyc, stb, we, adr, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(Lat + 1);

    // Reset in the middle of the sweep restarts it from word 0.
    do_reset(-1);
    do_reset(7);
    do_reset(-1);
    bus_cycle(1'b1, 1'b1, 1'b0, 5, '0, '0);
    bus_cycle(1'b1, 1'b1, 1'b0, 12, '0, '0);
    idle(Lat + 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
